dmem_responder: RTL and testbench

Word-addressed data-memory responder that serves the load/store requests (`lw` / `sw`, opcodes I_LOAD / S_TYPE) issued by the core's MEM stage. It sits on the memory side of the MEM-stage request/response interface, accepts one request at a time, inserts a configurable number of wait states, commits stores, and returns load data or a store acknowledge through a valid/ready response channel.

---
 rtl/dmem_responder.sv | 76 +++++++
 tb/tb_dmem_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory serving MEM-stage lw/sw with WAIT_CYCLES wait states.
// Optional address checking under DMEM_ALIGN_CHECK_EN (misaligned or out-of-range requests set rsp_err).
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_we, r_err;
  logic [AW-1:0]     r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_acc, w_err, w_enter_resp, w_unused;
  assign w_acc        = r_state == IDLE && req_valid;
  assign w_enter_resp = r_state == WAIT && r_cnt == 4'd0;
  assign w_unused     = ^{req_addr[31:AW+2], req_addr[1:0]};
`ifdef DMEM_ALIGN_CHECK_EN
  assign w_err = req_addr[1:0] != 2'b00 || req_addr >= 32'(4 * DEPTH);
`else
  assign w_err = 1'b0;
`endif
  // WAIT always lasts WAIT_CYCLES+1 cycles, giving a response WAIT_CYCLES+1 edges after accept
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (req_valid ? WAIT : IDLE) :
             r_state == WAIT ? (r_cnt == 4'd0 ? RESP : WAIT) :
             (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_we    <= req_we;
        r_err   <= w_err;
        r_idx   <= req_addr[AW+1:2];
        r_wdata <= req_wdata;
        r_cnt   <= 4'(WAIT_CYCLES);
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        rsp_rdata <= (r_we || r_err) ? '0 : r_mem[r_idx];
        rsp_err   <= r_err;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_enter_resp && r_we && !r_err) r_mem[r_idx] <= r_wdata;
  end
  assign rsp_valid = r_state == RESP;
  assign req_ready = rst_n && r_state == IDLE;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench with a timing/memory reference model for dmem_responder.
module tb_dmem_responder;
  localparam int DEPTH = 32;
  localparam int W     = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic z_req_valid = 1'b0, z_req_we = 1'b0, z_rsp_ready = 1'b0;
  logic [31:0] z_req_addr = '0, z_req_wdata = '0;
  logic z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, t_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dmem_responder #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: one outstanding request, answered WAIT+1 edges after accept
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          p_busy = 0, p_done = 0, p_we = 0, p_err = 0, p_known = 0;
  int          p_idx = 0, p_due = 0;
  logic [31:0] p_wd = '0, p_rd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_busy = 0;
      p_done = 0;
    end else begin
      if (p_busy && p_done && rsp_ready) begin
        p_busy = 0;
        p_done = 0;
      end else if (!p_busy && req_valid) begin
        p_busy = 1;
        p_done = 0;
        p_we   = req_we;
        p_wd   = req_wdata;
        p_idx  = int'((req_addr / 4) % DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
        p_err  = (req_addr % 4 != 0) || (req_addr >= 4 * DEPTH);
`else
        p_err  = 0;
`endif
        p_due  = cyc + 1 + W + 1;
      end
      if (p_busy && !p_done && cyc + 1 == p_due) begin
        p_done = 1;
        if (p_we && !p_err) begin
          m_mem[p_idx]   = p_wd;
          m_known[p_idx] = 1;
        end
        p_known = p_we || p_err || m_known[p_idx];
        p_rd    = (p_we || p_err) ? 32'h0 : m_mem[p_idx];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
    end else begin
      chk("req_ready", req_ready, !p_busy);
      chk("rsp_valid", rsp_valid, p_busy && p_done);
      if (p_busy && p_done) begin
        chk("rsp_err", rsp_err, p_err);
        if (p_known) chk("rsp_rdata", rsp_rdata, p_rd);
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 1, 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    t_acc = cyc;
  endtask

  task automatic finish_rsp(input int hold, output logic [31:0] rd, output logic e, output int lat);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("rsp_timeout", 1, 0);
    lat = cyc - t_acc;
    rd  = rsp_rdata;
    e   = rsp_err;
    repeat (hold) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, rd);
      chk("bp_req_ready", req_ready, 0);
    end
    #2 rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] d, input int hold,
                      output logic [31:0] rd, output logic e, output int lat);
    issue(we, a, d);
    finish_rsp(hold, rd, e, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic e;
    int lat, acc, prev, n;
    logic [31:0] z_exp [4];
    repeat (3) @(negedge clk);
    chk("reset_req_ready_low", req_ready, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_req_ready", req_ready, 1);
    chk("post_reset_rsp_valid", rsp_valid, 0);

    xact(1, 32'h10, 32'hDEADBEEF, 0, rd, e, lat);
    chk("sw_latency", lat, 3);
    chk("sw_rdata_zero", rd, 0);
    chk("sw_err", e, 0);
    xact(0, 32'h10, 0, 0, rd, e, lat);
    chk("lw_latency", lat, 3);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_err", e, 0);

    xact(0, 32'h10, 0, 5, rd, e, lat);
    chk("bp_data", rd, 32'hDEADBEEF);
    @(negedge clk);
    chk("bp_ready_after", req_ready, 1);

    xact(1, 32'h7C, 32'h0BADF00D, 1, rd, e, lat);
    xact(0, 32'h7C, 0, 0, rd, e, lat);
    chk("last_word", rd, 32'h0BADF00D);

`ifdef DMEM_ALIGN_CHECK_EN
    xact(1, 32'h12, 32'h12345678, 0, rd, e, lat);
    chk("misalign_err", e, 1);
    chk("misalign_latency", lat, 3);
    xact(1, 32'h80, 32'h12345678, 0, rd, e, lat);
    chk("range_err", e, 1);
    xact(0, 32'h10, 0, 0, rd, e, lat);
    chk("align_keep", rd, 32'hDEADBEEF);
    chk("align_keep_err", e, 0);
`else
    xact(1, 32'h84, 32'hA5A5A5A5, 0, rd, e, lat);
    chk("wrap_sw_err", e, 0);
    xact(0, 32'h04, 0, 0, rd, e, lat);
    chk("wrap_data", rd, 32'hA5A5A5A5);
    chk("wrap_err", e, 0);
`endif

    xact(1, 32'h08, 32'h7, 0, rd, e, lat);
    issue(1, 32'h08, 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_rsp_rdata", rsp_rdata, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    xact(0, 32'h08, 0, 0, rd, e, lat);
    chk("midrst_keep", rd, 32'h7);

    z_exp[1] = 32'h11;
    z_exp[3] = 32'h22;
    z_rsp_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      z_req_we    = (i % 2 == 0);
      z_req_addr  = 32'h20;
      z_req_wdata = (i == 0) ? 32'h11 : 32'h22;
      z_req_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!z_req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) chk("z_accept_timeout", 1, 0);
      @(posedge clk);
      #1 z_req_valid = 1'b0;
      acc = cyc;
      if (i > 0) chk("z_spacing_ge3", (acc - prev) >= 3, 1);
      prev = acc;
      n = 0;
      @(negedge clk);
      while (!z_rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) chk("z_rsp_timeout", 1, 0);
      chk("z_latency", cyc - acc, 1);
      chk("z_err", z_rsp_err, 0);
      if (i % 2 == 1) chk("z_rdata", z_rsp_rdata, z_exp[i]);
    end
    z_rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
